// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-port synchronous memory between an instruction-fetch port and a data port.
// Data wins by default; a saturating starvation counter forces a fetch grant after STARVE_MAX data wins.
module unified_mem_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_done,
    input  logic          dm_read,
    input  logic          dm_write,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic [DW-1:0] dm_rdata,
    output logic          dm_done,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int LW = $clog2(MEM_LAT + 1);
    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_I = 2'd1,
        ST_BUSY_D = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [LW-1:0]   r_lat;
    logic [SW-1:0]   r_starve;
    logic            r_is_write;

    logic            w_dm_req;
    logic            w_cooldown;
    logic            w_starve_ok;
    logic            w_lat_done;
    logic            w_grant_d;
    logic            w_grant_i;

    assign w_dm_req    = dm_read | dm_write;
    // The owner is still dropping its request while its done pulse is high.
    assign w_cooldown  = if_done | dm_done;
    assign w_starve_ok = (r_starve < SW'(STARVE_MAX));
    assign w_lat_done  = (r_lat == LW'(MEM_LAT));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_grant_d    = 1'b0;
        w_grant_i    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (!w_cooldown) begin
                    if (w_dm_req && (!if_req || w_starve_ok)) begin
                        w_grant_d    = 1'b1;
                        w_state_next = ST_BUSY_D;
                    end else if (if_req) begin
                        w_grant_i    = 1'b1;
                        w_state_next = ST_BUSY_I;
                    end
                end
            end
            ST_BUSY_I, ST_BUSY_D: begin
                if (w_lat_done) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_rdata   <= '0;
            if_done    <= 1'b0;
            dm_rdata   <= '0;
            dm_done    <= 1'b0;
            r_lat      <= '0;
            r_starve   <= '0;
            r_is_write <= 1'b0;
        end else begin
            mem_en  <= 1'b0;
            if_done <= 1'b0;
            dm_done <= 1'b0;

            if (w_grant_d) begin
                // A simultaneous read and write collapses into a single write.
                mem_en     <= 1'b1;
                mem_we     <= dm_write;
                mem_addr   <= dm_addr;
                mem_wdata  <= dm_wdata;
                r_is_write <= dm_write;
                r_lat      <= '0;
                if (if_req && w_starve_ok) begin
                    r_starve <= r_starve + SW'(1);
                end
            end else if (w_grant_i) begin
                mem_en   <= 1'b1;
                mem_we   <= 1'b0;
                mem_addr <= if_addr;
                r_lat    <= '0;
                r_starve <= '0;
            end

            if (r_state != ST_IDLE) begin
                if (w_lat_done) begin
                    if (r_state == ST_BUSY_I) begin
                        if_rdata <= mem_rdata;
                        if_done  <= 1'b1;
                    end else begin
                        dm_done <= 1'b1;
                        if (!r_is_write) begin
                            dm_rdata <= mem_rdata;
                        end
                    end
                end else begin
                    r_lat <= r_lat + LW'(1);
                end
            end
        end
    end

endmodule
